// File: rtl/mult_pkg.sv
// Shared widths, FSM state encoding and default watchdog limit for the
// multiply issue controller.
package mult_pkg;

  localparam int OP_W                = 32;
  localparam int PROD_W              = 64;
  localparam int DEFAULT_TIMEOUT_CYC = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mult_watchdog.sv
// Cycle counter for the BUSY phase; 'expired' flags the last cycle the
// controller is allowed to wait for mult_end.
module mult_watchdog
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == LAST);

endmodule

// File: rtl/mult_issue_ctrl.sv
// Initiator side of the iterative multiply handshake with watchdog timeout.
// Optional HI/LO architectural registers are built when MULT_HILO_EN is defined.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op1,
  input  logic [OP_W-1:0]   req_op2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [PROD_W-1:0] res_product,
  output logic              res_timeout,
  output logic              busy,
  output logic              mult_begin,
  output logic [OP_W-1:0]   mult_op1,
  output logic [OP_W-1:0]   mult_op2,
`ifdef MULT_HILO_EN
  output logic [OP_W-1:0]   hi,
  output logic [OP_W-1:0]   lo,
  input  logic              hilo_we,
  input  logic              hilo_wsel,
  input  logic [OP_W-1:0]   hilo_wdata,
`endif
  input  logic [PROD_W-1:0] mult_product,
  input  logic              mult_end
);

  state_t state, state_next;
  logic   accept, done_ok, done_to, res_take;
  logic   expired;

  mult_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (accept),
    .enable  (state == ST_BUSY),
    .expired (expired)
  );

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    done_to    = 1'b0;
    res_take   = 1'b0;
    case (state)
      ST_IDLE: if (req_valid) begin
        accept     = 1'b1;
        state_next = ST_BUSY;
      end
      ST_BUSY: if (mult_end) begin
        done_ok    = 1'b1;
        state_next = ST_RESP;
      end else if (expired) begin
        done_to    = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: if (res_ready) begin
        res_take   = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      mult_begin  <= 1'b0;
      mult_op1    <= '0;
      mult_op2    <= '0;
      res_valid   <= 1'b0;
      res_product <= '0;
      res_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        mult_op1   <= req_op1;
        mult_op2   <= req_op2;
        mult_begin <= 1'b1;
      end
      // mult_end has priority over the watchdog when both land together.
      if (done_ok || done_to) begin
        mult_begin  <= 1'b0;
        res_valid   <= 1'b1;
        res_product <= done_ok ? mult_product : '0;
        res_timeout <= done_to;
      end
      if (res_take) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

`ifdef MULT_HILO_EN
  // A successful product commit overrides a same-cycle software write.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else if (res_take && !res_timeout) begin
      hi <= res_product[PROD_W-1:OP_W];
      lo <= res_product[OP_W-1:0];
    end else if (hilo_we) begin
      if (hilo_wsel) hi <= hilo_wdata;
      else           lo <= hilo_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed-vector bench for mult_issue_ctrl with hand-computed expectations.
// Covers HI/LO behaviour too when built with MULT_HILO_EN.
module tb_mult_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [31:0] req_op1, req_op2;
  logic        res_valid, res_ready;
  logic [63:0] res_product;
  logic        res_timeout, busy, mult_begin;
  logic [31:0] mult_op1, mult_op2;
  logic [63:0] mult_product;
  logic        mult_end;
`ifdef MULT_HILO_EN
  logic [31:0] hi, lo, hilo_wdata;
  logic        hilo_we, hilo_wsel;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_issue_ctrl #(.TIMEOUT_CYC(64)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_product  (res_product),
    .res_timeout  (res_timeout),
    .busy         (busy),
    .mult_begin   (mult_begin),
    .mult_op1     (mult_op1),
    .mult_op2     (mult_op2),
`ifdef MULT_HILO_EN
    .hi           (hi),
    .lo           (lo),
    .hilo_we      (hilo_we),
    .hilo_wsel    (hilo_wsel),
    .hilo_wdata   (hilo_wdata),
`endif
    .mult_product (mult_product),
    .mult_end     (mult_end)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, hold mult_end low, then assert it so it is sampled on
  // the lat-th edge after acceptance. Leaves the DUT in RESP.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] prod);
    logic hold_ok;
    req_op1   = a;
    req_op2   = b;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    req_op1   = 32'hDEAD_BEEF;
    req_op2   = 32'hCAFE_F00D;
    hold_ok   = 1'b1;
    for (int i = 0; i < lat - 1; i++) begin
      if (mult_begin !== 1'b1 || mult_op1 !== a || mult_op2 !== b) hold_ok = 1'b0;
      tick();
    end
    check("op_hold", {63'd0, hold_ok}, 64'd1);
    mult_product = prod;
    mult_end     = 1'b1;
    tick();
    mult_end     = 1'b0;
    mult_product = 64'h5A5A_5A5A_5A5A_5A5A;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic stable;
    resetn       = 1'b0;
    req_valid    = 1'b0;
    req_op1      = '0;
    req_op2      = '0;
    res_ready    = 1'b0;
    mult_product = '0;
    mult_end     = 1'b0;
`ifdef MULT_HILO_EN
    hilo_we    = 1'b0;
    hilo_wsel  = 1'b0;
    hilo_wdata = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("rst_begin", {63'd0, mult_begin}, 64'd0);
    check("rst_valid", {63'd0, res_valid}, 64'd0);
    check("rst_prod", res_product, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    resetn = 1'b1;
    tick();
    check("rst_ready", {63'd0, req_ready}, 64'd1);

    // Basic 0x1111 squared, completion 33 cycles after acceptance.
    run_op(32'h0000_1111, 32'h0000_1111, 33, 64'h0000_0000_0123_4321);
    check("basic_valid", {63'd0, res_valid}, 64'd1);
    check("basic_prod", res_product, 64'h0000_0000_0123_4321);
    check("basic_to", {63'd0, res_timeout}, 64'd0);
    check("basic_begin_low", {63'd0, mult_begin}, 64'd0);
    handshake();
    check("basic_done", {63'd0, res_valid}, 64'd0);
    check("basic_idle", {63'd0, req_ready}, 64'd1);

    // Signed product passes through untouched.
    run_op(32'hFFFF_FFFF, 32'h0000_0002, 5, 64'hFFFF_FFFF_FFFF_FFFE);
    check("signed_prod", res_product, 64'hFFFF_FFFF_FFFF_FFFE);
    handshake();

    // Backpressure with a second request waiting.
    run_op(32'd6, 32'd9, 3, 64'd54);
    req_op1   = 32'd7;
    req_op2   = 32'd3;
    req_valid = 1'b1;
    stable    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_product !== 64'd54 || req_ready !== 1'b0 ||
          mult_begin !== 1'b0) stable = 1'b0;
    end
    check("bp_stable", {63'd0, stable}, 64'd1);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_idle", {63'd0, req_ready}, 64'd1);
    check("bp_no_early_accept", {63'd0, mult_begin}, 64'd0);
    tick();
    req_valid = 1'b0;
    check("bp_second_begin", {63'd0, mult_begin}, 64'd1);
    check("bp_second_op1", {32'd0, mult_op1}, 64'd7);
    mult_product = 64'd21;
    mult_end     = 1'b1;
    tick();
    mult_end     = 1'b0;
    check("bp_second_prod", res_product, 64'd21);
    handshake();

    // Timeout: no mult_end, response after the 64th BUSY cycle.
    req_op1   = 32'd3;
    req_op2   = 32'd4;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (63) tick();
    check("to_not_yet", {63'd0, res_valid}, 64'd0);
    tick();
    check("to_valid", {63'd0, res_valid}, 64'd1);
    check("to_flag", {63'd0, res_timeout}, 64'd1);
    check("to_prod", res_product, 64'd0);
    check("to_begin_low", {63'd0, mult_begin}, 64'd0);
    mult_product = 64'h1111_2222_3333_4444;
    mult_end     = 1'b1;
    repeat (2) tick();
    mult_end     = 1'b0;
    check("to_late_prod", res_product, 64'd0);
    check("to_late_flag", {63'd0, res_timeout}, 64'd1);
    handshake();
    check("to_idle", {63'd0, req_ready}, 64'd1);

`ifdef MULT_HILO_EN
    run_op(32'h0000_1111, 32'h0000_1111, 4, 64'h0000_0000_0123_4321);
    hilo_we    = 1'b1;
    hilo_wsel  = 1'b0;
    hilo_wdata = 32'hAAAA_5555;
    res_ready  = 1'b1;
    tick();
    res_ready  = 1'b0;
    check("hilo_hi", {32'd0, hi}, 64'd0);
    check("hilo_commit_wins", {32'd0, lo}, 64'h0123_4321);
    tick();
    hilo_we = 1'b0;
    check("hilo_write_lo", {32'd0, lo}, 64'hAAAA_5555);
`endif

    // Asynchronous reset in the middle of an operation.
    req_op1   = 32'h1234_5678;
    req_op2   = 32'd2;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("midrst_pre_begin", {63'd0, mult_begin}, 64'd1);
    #2 resetn = 1'b0;
    #1;
    check("midrst_begin", {63'd0, mult_begin}, 64'd0);
    check("midrst_valid", {63'd0, res_valid}, 64'd0);
    tick();
    resetn = 1'b1;
    tick();
    check("midrst_ready", {63'd0, req_ready}, 64'd1);
    check("midrst_op1", {32'd0, mult_op1}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
